// File: rtl/ide_xfer_pkg.sv
// rtl/ide_xfer_pkg.sv - shared state encoding and direction/mode constants for the IDE transfer engine
package ide_xfer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } xfer_state_t;

  localparam logic DIR_HOST_RD = 1'b0;
  localparam logic DIR_HOST_WR = 1'b1;
  localparam logic MODE_PIO    = 1'b0;
  localparam logic MODE_DMA    = 1'b1;

endpackage

// File: rtl/ide_credit_counter.sv
// rtl/ide_credit_counter.sv - saturating bank-credit counter with simultaneous inc/dec and overflow flag
module ide_credit_counter #(
  parameter int NBANKS = 4,
  parameter int CNT_W  = 3
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(NBANKS);

  logic full;

  assign full = (count == FULL);
  // An add that would exceed NBANKS is dropped; paired with a consume it nets to zero instead.
  assign ovf  = !clr && inc && !dec && full;

  always_ff @(posedge clk) begin
    if (!reset_) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !dec && !full) begin
      count <= count + CNT_W'(1);
    end else if (dec && !inc && count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/ide_xfer_engine.sv
// rtl/ide_xfer_engine.sv - multi-bank, multi-block IDE data-phase engine (PIO and multiword DMA)
module ide_xfer_engine
  import ide_xfer_pkg::*;
#(
  parameter int POS_W  = 8,
  parameter int NBANKS = 4,
  parameter int BANK_W = 2
) (
  input  logic                    clk,
  input  logic                    reset_,
  input  logic                    cfg_start,
  input  logic                    cfg_dir,
  input  logic                    cfg_dma,
  input  logic [POS_W-1:0]        cfg_words,
  input  logic [7:0]              cfg_blocks,
  input  logic                    cfg_abort,
  input  logic                    credit_add,
  input  logic                    host_rd_stb,
  input  logic                    host_wr_stb,
  input  logic                    dmack_act,
  input  logic                    irq_clr,
  output logic [BANK_W+POS_W-1:0] buf_addr,
  output logic                    buf_we,
  output logic                    bsy,
  output logic                    drq,
  output logic                    dmarq,
  output logic                    block_done,
  output logic [BANK_W-1:0]       done_bank,
  output logic                    xfer_done,
  output logic                    irq,
  output logic                    err_ovr
);

  xfer_state_t       state, state_nxt;
  logic              dir_q, dma_q;
  logic [POS_W-1:0]  words_q, pos;
  logic [BANK_W-1:0] bank;
  logic [7:0]        blocks_left;
  logic              dmarq_off, err_q, irq_q;
  logic [BANK_W:0]   credits;
  logic              credit_ovf;

  logic start_ok, dir_stb, counted, blk_end, stray, more_credit;

  assign start_ok    = cfg_start && !cfg_abort && (state == ST_IDLE);
  assign dir_stb     = (dir_q == DIR_HOST_WR) ? host_wr_stb : host_rd_stb;
  assign counted     = (state == ST_XFER) && !cfg_abort && dir_stb &&
                       ((dma_q == MODE_PIO) || dmack_act);
  assign blk_end     = counted && (pos == words_q);
  assign stray       = (state != ST_XFER) && dir_stb;
  // Credits left after this block's consume, including an add landing in the same cycle.
  assign more_credit = (credits > (BANK_W+1)'(1)) || credit_add;

  ide_credit_counter #(
    .NBANKS(NBANKS),
    .CNT_W (BANK_W+1)
  ) u_credits (
    .clk   (clk),
    .reset_(reset_),
    .clr   (start_ok),
    .inc   (credit_add),
    .dec   (blk_end),
    .count (credits),
    .ovf   (credit_ovf)
  );

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    bsy       = 1'b0;
    drq       = 1'b0;
    dmarq     = 1'b0;
    xfer_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_ok) begin
          state_nxt = (cfg_blocks == 8'd0) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        bsy = 1'b1;
        if (credits != '0) begin
          state_nxt = ST_XFER;
        end
      end
      ST_XFER: begin
        drq   = (dma_q == MODE_PIO);
        dmarq = (dma_q == MODE_DMA) && !dmarq_off;
        if (blk_end) begin
          if (blocks_left == 8'd1) begin
            state_nxt = ST_DONE;
          end else if (more_credit) begin
            state_nxt = ST_XFER;
          end else begin
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_DONE: begin
        xfer_done = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (cfg_abort) begin
      state_nxt = ST_IDLE;
      xfer_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      dir_q       <= DIR_HOST_RD;
      dma_q       <= MODE_PIO;
      words_q     <= '0;
      pos         <= '0;
      bank        <= '0;
      blocks_left <= '0;
      dmarq_off   <= 1'b0;
      err_q       <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      if (start_ok) begin
        dir_q       <= cfg_dir;
        dma_q       <= cfg_dma;
        words_q     <= cfg_words;
        pos         <= '0;
        bank        <= '0;
        blocks_left <= cfg_blocks;
      end else if (blk_end) begin
        pos         <= '0;
        bank        <= bank + BANK_W'(1);
        blocks_left <= blocks_left - 8'd1;
      end else if (counted) begin
        pos <= pos + POS_W'(1);
      end

      // DMARQ is withdrawn once the host acknowledges the last word, ahead of its final strobe.
      dmarq_off <= (state == ST_XFER) && !blk_end &&
                   (dmarq_off || ((dma_q == MODE_DMA) && dmack_act && (pos == words_q)));

      if (start_ok) begin
        err_q <= 1'b0;
      end else if (stray || credit_ovf) begin
        err_q <= 1'b1;
      end

      if ((state == ST_DONE) && !cfg_abort) begin
        irq_q <= 1'b1;
      end else if (irq_clr) begin
        irq_q <= 1'b0;
      end
    end
  end

  assign buf_addr   = {bank, pos};
  assign buf_we     = counted && (dir_q == DIR_HOST_WR);
  assign block_done = blk_end;
  assign done_bank  = blk_end ? bank : '0;
  assign irq        = irq_q;
  assign err_ovr    = err_q;

endmodule

// File: doc/ide_xfer_engine.md
Name: ide_xfer_engine

Overview:
Parametrised data-phase transfer engine for the IDE device side. It generalises the fixed 2-bank buffer with its 8-bit position/target pair into N banks, configurable block size and multi-block transfers. Banks are handed over between CPU/SD-card and host by credit, and both PIO and multiword DMA are supported. It sits between the bus front end (decoded, synchronised single-cycle host strobes) and the sector buffer RAM, and raises status/IRQ towards the RISC-V.

Parameters:
POS_W, 8, word-position width; bank size = 2^POS_W 16-bit words
NBANKS, 4, number of buffer banks (power of 2, >=2)
BANK_W, 2, log2(NBANKS)

Ports:
clk  in  1  system clock
reset_  in  1  reset; one clock, synchronous, active-low
cfg_start  in  1  pulse: arm transfer using cfg_* (accepted only in IDLE)
cfg_dir  in  1  1 = host writes to buffer, 0 = host reads from buffer
cfg_dma  in  1  1 = multiword DMA, 0 = PIO
cfg_words  in  POS_W  last word index of a block (block = cfg_words+1 words)
cfg_blocks  in  8  block count; 0 = no-op
cfg_abort  in  1  pulse: cancel transfer
credit_add  in  1  pulse: one bank ready for host (filled if dir=0, emptied if dir=1)
host_rd_stb  in  1  completed host read of data register / DMA word
host_wr_stb  in  1  completed host write of data register / DMA word
dmack_act  in  1  host DMACK currently asserted
irq_clr  in  1  pulse: clear irq
buf_addr  out  BANK_W+POS_W  buffer word address {bank,pos}, registered
buf_we  out  1  buffer write enable
bsy  out  1  transfer armed, waiting for credit
drq  out  1  PIO data request
dmarq  out  1  DMA request
block_done  out  1  pulse: a bank fully consumed by host
done_bank  out  BANK_W  bank index valid with block_done
xfer_done  out  1  pulse: last block complete
irq  out  1  sticky completion interrupt
err_ovr  out  1  sticky: strobe outside XFER, or credit_add while credits==NBANKS

Behaviour:
- Reset (reset_ low at clk edge): state IDLE, all outputs 0, pos/bank/credits/blocks_left 0.
- States: IDLE, WAIT, XFER, DONE.
- IDLE: on cfg_start, latch dir/dma/words. Clear pos, bank, credits and err_ovr. blocks_left = cfg_blocks. Next state is DONE if cfg_blocks==0, else WAIT. cfg_start in any other state is ignored.
- WAIT: bsy=1, drq=dmarq=0. When credits>0, go to XFER next cycle.
- XFER: drq = ~dma. dmarq = dma, cleared one cycle after dmack_act is seen with pos==words, i.e. before the final strobe; re-asserted on entry to the next block.
- Counted strobe: host_rd_stb if dir=0, host_wr_stb if dir=1. In DMA mode a strobe counts only when dmack_act=1. Opposite-direction strobes are ignored with no error.
- buf_we = counted host_wr_stb (combinational), written at the current buf_addr. pos increments on the following edge. Read data for the next word is valid 1 cycle after a strobe.
- Strobe with pos==words ends the block:
  - block_done=1 and done_bank=bank.
  - bank = bank+1 mod NBANKS; pos = 0; credits-1; blocks_left-1.
  - Next state: DONE if blocks_left was 1; else XFER if post-decrement credits>0; else WAIT.
- credits: saturating 0..NBANKS, width BANK_W+1. credit_add and consume in the same cycle gives net 0, no error. credit_add at NBANKS is dropped and sets err_ovr.
- Counted-direction strobe in IDLE or WAIT: dropped, sets err_ovr.
- DONE: one cycle. xfer_done=1, set irq, go to IDLE, drq=dmarq=bsy=0.
- irq stays high until irq_clr. If irq_clr and DONE occur in the same cycle, set wins.
- cfg_abort (any state): IDLE next cycle, drq/dmarq/bsy 0, no xfer_done or irq. Abort takes priority over a simultaneous strobe; that strobe is not counted and buf_we is suppressed.
- pos wraps only through block end; words = 2^POS_W-1 uses the full bank.

Decomposition:
- Package ide_xfer_pkg: state encoding (IDLE/WAIT/XFER/DONE), DIR_HOST_RD/DIR_HOST_WR and MODE_PIO/MODE_DMA constants.
- Sub-module ide_credit_counter: saturating up/down counter with simultaneous inc/dec and overflow flag, parametrised by NBANKS.

Test Plan:
- PIO read, words=3, blocks=2, 2 credits given: 8 host_rd_stb -> buf_addr 0..3 then 0x100..0x103 (POS_W=8). block_done with done_bank 0 then 1. xfer_done and irq after 8th strobe. drq low afterwards.
- PIO write, credit starvation: blocks=3, 1 credit. After 4 strobes -> block_done, state WAIT, bsy=1, drq=0. credit_add -> drq=1 next-next cycle. buf_we exactly 12 times.
- DMA read, words=1: strobes without dmack_act are not counted. With dmack_act and pos==1, dmarq drops before the final strobe. Final strobe -> xfer_done.
- Bank wrap, NBANKS=4, blocks=6, credits kept topped up -> done_bank sequence 0,1,2,3,0,1.
- Errors: strobe in IDLE -> err_ovr=1. 5th credit_add with NBANKS=4 -> err_ovr stays 1, credits stay 4. New cfg_start clears err_ovr.
- Abort mid-block at pos=2 with a simultaneous strobe -> buf_we=0, IDLE next cycle, no irq. A cfg_start with cfg_blocks=0 -> xfer_done 2 cycles later.
